cpu6502_ls_core: RTL
====================

Name: cpu6502_ls_core

Overview:
- Multi-cycle 6502-subset CPU core; successor to the first load/store core.
- Adds indexed addressing, register transfers, inc/dec, N/Z flags, JMP, a parametrised reset PC or vector, a rdy stall input and an illegal-opcode policy.
- Sits between the shared 64 KB memory bus and the debug/monitor logic.

Parameters:
RESET_PC, 16'h0000, PC loaded at reset when USE_VECTOR=0
USE_VECTOR, 0, 1: PC fetched from $FFFC (lo) and $FFFD (hi) after reset
HALT_ON_ILLEGAL, 1, 1: undefined opcode enters HALT; 0: executes as 2-cycle NOP

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  synchronous, active-high
rdy  in  1  0 = freeze core (all regs, outputs, state hold)
di  in  8  read data; memory is combinational on ab, sampled at the posedge ending the cycle
ab  out  16  registered address
do  out  8  registered write data, valid while we=1
we  out  1  registered write enable
sync  out  1  1 during opcode-fetch cycle
halted  out  1  1 in HALT state
dbg_a, dbg_x, dbg_y  out  8 each  register file A/X/Y
dbg_pc  out  16  program counter
dbg_nz  out  2  {N,Z}

Behaviour:
- Reset (sampled high at posedge; overrides rdy and any in-flight cycle):
  - A=X=Y=0, N=Z=0, we=0, do=0, halted=0.
  - USE_VECTOR=0: state=FETCH, ab=pc=RESET_PC, sync=1.
  - USE_VECTOR=1: state=VEC_LO, ab=16'hFFFC, sync=0; VEC_LO captures lo, ab=FFFD; VEC_HI captures hi, then pc=ab={hi,lo}, FETCH.
- States: VEC_LO, VEC_HI, FETCH, OPL, OPH, IDXFIX, MEM, HALT.
- FETCH: opcode<=di, pc+=1, ab<=pc+1. Next state by opcode:
  - Implied: execute at end of OPL.
  - Immediate: operand read in OPL.
  - All other modes: OPL captures operand lo.
- Supported opcodes (hex):
  - LDA A9 A5 B5 AD BD B9; LDX A2 A6 B6 AE BE; LDY A0 A4 B4 AC BC.
  - STA 85 95 8D 9D 99; STX 86 96 8E; STY 84 94 8C.
  - TAX AA, TAY A8, TXA 8A, TYA 98, INX E8, INY C8, DEX CA, DEY 88, NOP EA, JMP-abs 4C.
- Cycle counts (FETCH to next FETCH; identical to NMOS 6502):
  - imm/implied 2; zp 3; zp,idx 4; abs 4; JMP 3.
  - abs,idx load: 4, or 5 on page cross.
  - abs,idx store: always 5.
- Index: LDX/STX zp-indexed and LDX abs-indexed use Y; LDA B9 and STA 99 use Y; all other indexed modes use X.
- Address arithmetic:
  - zp,idx is an 8-bit add, wrapping within page 0 (e.g. $F0+X=$20 gives $0010).
  - abs,idx is a 16-bit add; on carry out of the low byte a load spends IDXFIX with ab={hi,lo+idx}; the next cycle uses the corrected address.
  - Address $FFFF + idx wraps mod 2^16.
- Stores: in the MEM cycle ab=EA, do=reg, we=1 for exactly one cycle; we returns to 0 on the following FETCH.
- Loads: the register is written at the posedge ending MEM; N=bit7, Z=(value==0).
- Transfers, INX/INY/DEX/DEY:
  - Update N/Z.
  - INC/DEC wrap $FF↔$00 without affecting anything else.
  - TAX/TXA etc. copy 8 bits.
- Flags: stores, NOP and JMP leave N/Z unchanged.
- PC: increments once per opcode/operand byte fetched; wraps $FFFF→$0000.
- JMP: pc={OPH byte, OPL byte}.
- rdy=0: every register holds, including ab/we/do. A stalled write keeps we=1 until rdy returns, and is performed once.
- Undefined opcode:
  - HALT_ON_ILLEGAL=1: HALT (ab holds pc of following byte, we=0, halted=1); leaves only via reset.
  - HALT_ON_ILLEGAL=0: 2-cycle NOP.

Test Plan:
- Reset vector: USE_VECTOR=1, mem[FFFC]=34, mem[FFFD]=12 → first sync=1 cycle has ab=$1234, exactly 3 cycles after reset release.
- Load/flags: A9 00; A2 80 → A=0, Z=1 after cycle 2; then X=$80, N=1, Z=0; 4 cycles total.
- ZP wrap: X=$40, B5 F0, mem[$0030]=$5A → A=$5A, read address $0030, 4 cycles.
- Page cross: Y=$FF, B9 01 20 → reads $2100 in 5 cycles; same with Y=$01 reads $2002 in 4 cycles; 99 01 20 always 5 cycles, one we pulse at $2100.
- Stall: rdy=0 for 3 cycles during 8D 00 30 write cycle → we=1 held 4 cycles, ab=$3000, do=A, memory written once.
- Illegal opcode/reset: opcode $02 with HALT_ON_ILLEGAL=1 → halted=1, we=0 forever; reset asserted mid-store → next cycle we=0, A=X=Y=0.

Source files
------------

// File: rtl/cpu6502_ls_core.sv
// Multi-cycle 6502-subset CPU core: loads/stores with zp/abs/indexed modes,
// register transfers, inc/dec, N/Z flags, JMP, rdy stall and illegal-opcode policy.
module cpu6502_ls_core #(
    parameter logic [15:0] RESET_PC        = 16'h0000,
    parameter logic        USE_VECTOR      = 1'b0,
    parameter logic        HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic [7:0]  di,
    output logic [15:0] ab,
    output logic [7:0]  dout,
    output logic        we,
    output logic        sync,
    output logic        halted,
    output logic [7:0]  dbg_a,
    output logic [7:0]  dbg_x,
    output logic [7:0]  dbg_y,
    output logic [15:0] dbg_pc,
    output logic [1:0]  dbg_nz
);

    typedef enum logic [2:0] {
        VEC_LO, VEC_HI, FETCH, OPL, OPH, IDXFIX, MEM, HALT
    } state_t;

    typedef enum logic [2:0] {
        M_IMP, M_IMM, M_ZP, M_ZPI, M_ABS, M_ABI, M_JMP
    } mode_t;

    typedef enum logic [1:0] {R_A, R_X, R_Y} reg_t;

    typedef enum logic [3:0] {
        I_NOP, I_TAX, I_TAY, I_TXA, I_TYA, I_INX, I_INY, I_DEX, I_DEY
    } iop_t;

    typedef struct packed {
        logic  legal;
        mode_t mode;
        reg_t  rsel;
        logic  store;
        logic  use_y;
        iop_t  iop;
    } dec_t;

    // rsel names the loaded/stored register, or the destination for implied ops
    function automatic dec_t decode(input logic [7:0] o);
        dec_t d;
        d = '{legal: 1'b1, mode: M_IMP, rsel: R_A, store: 1'b0, use_y: 1'b0, iop: I_NOP};
        case (o)
            8'hA9: d.mode = M_IMM;
            8'hA5: d.mode = M_ZP;
            8'hB5: d.mode = M_ZPI;
            8'hAD: d.mode = M_ABS;
            8'hBD: d.mode = M_ABI;
            8'hB9: begin d.mode = M_ABI; d.use_y = 1'b1; end
            8'hA2: begin d.mode = M_IMM; d.rsel = R_X; end
            8'hA6: begin d.mode = M_ZP;  d.rsel = R_X; end
            8'hB6: begin d.mode = M_ZPI; d.rsel = R_X; d.use_y = 1'b1; end
            8'hAE: begin d.mode = M_ABS; d.rsel = R_X; end
            8'hBE: begin d.mode = M_ABI; d.rsel = R_X; d.use_y = 1'b1; end
            8'hA0: begin d.mode = M_IMM; d.rsel = R_Y; end
            8'hA4: begin d.mode = M_ZP;  d.rsel = R_Y; end
            8'hB4: begin d.mode = M_ZPI; d.rsel = R_Y; end
            8'hAC: begin d.mode = M_ABS; d.rsel = R_Y; end
            8'hBC: begin d.mode = M_ABI; d.rsel = R_Y; end
            8'h85: begin d.mode = M_ZP;  d.store = 1'b1; end
            8'h95: begin d.mode = M_ZPI; d.store = 1'b1; end
            8'h8D: begin d.mode = M_ABS; d.store = 1'b1; end
            8'h9D: begin d.mode = M_ABI; d.store = 1'b1; end
            8'h99: begin d.mode = M_ABI; d.store = 1'b1; d.use_y = 1'b1; end
            8'h86: begin d.mode = M_ZP;  d.rsel = R_X; d.store = 1'b1; end
            8'h96: begin d.mode = M_ZPI; d.rsel = R_X; d.store = 1'b1; d.use_y = 1'b1; end
            8'h8E: begin d.mode = M_ABS; d.rsel = R_X; d.store = 1'b1; end
            8'h84: begin d.mode = M_ZP;  d.rsel = R_Y; d.store = 1'b1; end
            8'h94: begin d.mode = M_ZPI; d.rsel = R_Y; d.store = 1'b1; end
            8'h8C: begin d.mode = M_ABS; d.rsel = R_Y; d.store = 1'b1; end
            8'hAA: begin d.iop = I_TAX; d.rsel = R_X; end
            8'hA8: begin d.iop = I_TAY; d.rsel = R_Y; end
            8'h8A: begin d.iop = I_TXA; d.rsel = R_A; end
            8'h98: begin d.iop = I_TYA; d.rsel = R_A; end
            8'hE8: begin d.iop = I_INX; d.rsel = R_X; end
            8'hC8: begin d.iop = I_INY; d.rsel = R_Y; end
            8'hCA: begin d.iop = I_DEX; d.rsel = R_X; end
            8'h88: begin d.iop = I_DEY; d.rsel = R_Y; end
            8'hEA: d.iop = I_NOP;
            8'h4C: d.mode = M_JMP;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    state_t      state, state_n;
    logic [15:0] pc, pc_n, ab_n, ea, ea_n;
    logic [7:0]  a, a_n, x, x_n, y, y_n;
    logic [7:0]  op, op_n, lo, lo_n, dout_n;
    logic        n, n_n, z, z_n, we_n;
    dec_t        dc;
    logic [7:0]  idx, sreg, wval;
    logic        wen;
    logic [8:0]  lo_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= USE_VECTOR ? VEC_LO : FETCH;
            ab    <= USE_VECTOR ? 16'hFFFC : RESET_PC;
            pc    <= RESET_PC;
            ea    <= 16'h0000;
            a     <= 8'h00;
            x     <= 8'h00;
            y     <= 8'h00;
            n     <= 1'b0;
            z     <= 1'b0;
            op    <= 8'h00;
            lo    <= 8'h00;
            dout  <= 8'h00;
            we    <= 1'b0;
        end else if (rdy) begin
            state <= state_n;
            ab    <= ab_n;
            pc    <= pc_n;
            ea    <= ea_n;
            a     <= a_n;
            x     <= x_n;
            y     <= y_n;
            n     <= n_n;
            z     <= z_n;
            op    <= op_n;
            lo    <= lo_n;
            dout  <= dout_n;
            we    <= we_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ab_n    = ab;
        ea_n    = ea;
        a_n     = a;
        x_n     = x;
        y_n     = y;
        n_n     = n;
        z_n     = z;
        op_n    = op;
        lo_n    = lo;
        dout_n  = dout;
        we_n    = we;
        wen     = 1'b0;
        wval    = 8'h00;
        // in FETCH the opcode is still on di, elsewhere it is latched
        dc      = decode(state == FETCH ? di : op);
        idx     = dc.use_y ? y : x;
        sreg    = (dc.rsel == R_X) ? x : ((dc.rsel == R_Y) ? y : a);
        lo_sum  = {1'b0, lo} + {1'b0, idx};

        case (state)
            VEC_LO: begin
                lo_n    = di;
                ab_n    = 16'hFFFD;
                state_n = VEC_HI;
            end
            VEC_HI: begin
                pc_n    = {di, lo};
                ab_n    = {di, lo};
                state_n = FETCH;
            end
            FETCH: begin
                op_n    = di;
                pc_n    = pc + 16'd1;
                ab_n    = pc + 16'd1;
                we_n    = 1'b0;
                state_n = (!dc.legal && HALT_ON_ILLEGAL) ? HALT : OPL;
            end
            OPL: begin
                case (dc.mode)
                    M_IMP: begin
                        ab_n    = pc;
                        state_n = FETCH;
                        wen     = (dc.iop != I_NOP);
                        case (dc.iop)
                            I_TAX, I_TAY: wval = a;
                            I_TXA:        wval = x;
                            I_TYA:        wval = y;
                            I_INX:        wval = x + 8'd1;
                            I_INY:        wval = y + 8'd1;
                            I_DEX:        wval = x - 8'd1;
                            I_DEY:        wval = y - 8'd1;
                            default:      wval = 8'h00;
                        endcase
                    end
                    M_IMM: begin
                        wen     = 1'b1;
                        wval    = di;
                        pc_n    = pc + 16'd1;
                        ab_n    = pc + 16'd1;
                        state_n = FETCH;
                    end
                    M_ZP: begin
                        pc_n    = pc + 16'd1;
                        ab_n    = {8'h00, di};
                        we_n    = dc.store;
                        dout_n  = sreg;
                        state_n = MEM;
                    end
                    M_ZPI: begin
                        pc_n    = pc + 16'd1;
                        ab_n    = {8'h00, di};
                        ea_n    = {8'h00, di + idx};
                        state_n = IDXFIX;
                    end
                    default: begin
                        lo_n    = di;
                        pc_n    = pc + 16'd1;
                        ab_n    = pc + 16'd1;
                        state_n = OPH;
                    end
                endcase
            end
            OPH: begin
                pc_n = pc + 16'd1;
                ea_n = {di, lo} + {8'h00, idx};
                case (dc.mode)
                    M_JMP: begin
                        pc_n    = {di, lo};
                        ab_n    = {di, lo};
                        state_n = FETCH;
                    end
                    M_ABS: begin
                        ab_n    = {di, lo};
                        we_n    = dc.store;
                        dout_n  = sreg;
                        state_n = MEM;
                    end
                    default: begin
                        // uncorrected high byte first; stores always take the fix cycle
                        ab_n    = {di, lo_sum[7:0]};
                        state_n = (dc.store || lo_sum[8]) ? IDXFIX : MEM;
                    end
                endcase
            end
            IDXFIX: begin
                ab_n    = ea;
                we_n    = dc.store;
                dout_n  = sreg;
                state_n = MEM;
            end
            MEM: begin
                if (!dc.store) begin
                    wen  = 1'b1;
                    wval = di;
                end
                we_n    = 1'b0;
                ab_n    = pc;
                state_n = FETCH;
            end
            HALT: begin
                we_n = 1'b0;
            end
            default: state_n = HALT;
        endcase

        if (wen) begin
            case (dc.rsel)
                R_X:     x_n = wval;
                R_Y:     y_n = wval;
                default: a_n = wval;
            endcase
            n_n = wval[7];
            z_n = (wval == 8'h00);
        end
    end

    assign sync   = (state == FETCH);
    assign halted = (state == HALT);
    assign dbg_a  = a;
    assign dbg_x  = x;
    assign dbg_y  = y;
    assign dbg_pc = pc;
    assign dbg_nz = {n, z};

endmodule
